// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults, FSM state and index width for the result collector
package systolic_pkg;
  localparam int DATAWIDTH_DEF = 16;
  localparam int N_SIZE_DEF = 5;
  localparam int IDX_W = $clog2(N_SIZE_DEF);
  typedef enum logic {COLLECT, DRAIN} state_t;
endpackage

// File: rtl/collector_bank.sv
// collector_bank: one N x N result matrix; row-wide write port, combinational element read port
module collector_bank
  import systolic_pkg::*;
#(
  parameter int EW = 32,
  parameter int N = N_SIZE_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [N*EW-1:0] wrow,
  input  logic [IW-1:0] rrow,
  input  logic [IW-1:0] rcol,
  output logic [EW-1:0] rdata
);
  logic [N*EW-1:0] mem [N];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wrow;
  assign rdata = mem[rrow][rcol*EW +: EW];
endmodule

// File: rtl/systolic_result_collector.sv
// systolic_result_collector: buffers C rows and streams elements row-major; COLLECTOR_PINGPONG_EN adds a second bank
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int N_SIZE = N_SIZE_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [N_SIZE*2*DATAWIDTH-1:0] in_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*DATAWIDTH-1:0]        out_data,
  output logic [$clog2(N_SIZE)-1:0]     out_row,
  output logic [$clog2(N_SIZE)-1:0]     out_col,
  output logic                          out_last,
  output logic                          overflow
);
  localparam int EW = 2*DATAWIDTH;
  localparam int IW = $clog2(N_SIZE);
`ifdef COLLECTOR_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  state_t state;
  logic [IW-1:0] wr_cnt;
  logic wbank, rbank, ob;
  logic [1:0] full, full_nxt;
  logic [EW-1:0] rdata [2];
  logic fire, done, accept, wend;
  assign out_last = out_valid && out_row == IW'(N_SIZE-1) && out_col == IW'(N_SIZE-1);
  assign out_data = out_valid ? rdata[rbank] : '0;
  // a bank being drained frees up on its last transfer, so a row arriving then is still taken
  always_comb begin
    fire = out_valid && out_ready;
    done = fire && out_last;
    ob = NB == 2 ? ~rbank : rbank;
    accept = in_valid && (!full[wbank] || (done && wbank == rbank));
    wend = accept && wr_cnt == IW'(N_SIZE-1);
    full_nxt = full;
    if (done) full_nxt[rbank] = 1'b0;
    if (wend) full_nxt[wbank] = 1'b1;
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b < NB) begin : g_mem
      collector_bank #(.EW(EW), .N(N_SIZE), .IW(IW)) u_bank (
        .clk(clk), .we(accept && wbank == 1'(b)), .waddr(wr_cnt), .wrow(in_row),
        .rrow(out_row), .rcol(out_col), .rdata(rdata[b])
      );
    end else begin : g_none
      assign rdata[b] = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
      wr_cnt <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      full <= '0;
      out_valid <= 1'b0;
      out_row <= '0;
      out_col <= '0;
      overflow <= 1'b0;
    end else begin
      full <= full_nxt;
      if (in_valid && !accept) overflow <= 1'b1;
      if (accept) wr_cnt <= wend ? '0 : wr_cnt + 1'b1;
      if (wend && NB == 2) wbank <= ~wbank;
      if (done) begin
        out_row <= '0;
        out_col <= '0;
        rbank <= ob;
        out_valid <= full_nxt[ob];
        state <= full_nxt[ob] ? DRAIN : COLLECT;
      end else if (fire) begin
        out_col <= out_col == IW'(N_SIZE-1) ? '0 : out_col + 1'b1;
        if (out_col == IW'(N_SIZE-1)) out_row <= out_row + 1'b1;
      end else if (state == COLLECT && wend) begin
        state <= DRAIN;
        out_valid <= 1'b1;
        rbank <= wbank;
        out_row <= '0;
        out_col <= '0;
      end
    end
  end
endmodule
